// File: rtl/sensor_init_pkg.sv
// Shared definitions for the table-driven camera sensor initialiser:
// opcodes, controller states and ROM entry field helpers.
package sensor_init_pkg;

    localparam logic [1:0] OP_WRITE        = 2'b00;
    localparam logic [1:0] OP_WRITE_VERIFY = 2'b01;
    localparam logic [1:0] OP_DELAY        = 2'b10;
    localparam logic [1:0] OP_END          = 2'b11;

    typedef enum logic [3:0] {
        PWR_DN,
        RST_HOLD,
        SETTLE,
        FETCH,
        DECODE,
        WR,
        WAIT_W,
        RD,
        WAIT_R,
        RETRY,
        NEXT,
        DLY,
        DONE,
        ERROR
    } state_e;

    // Entry layout is {op[1:0], addr[aw-1:0], data[dw-1:0]}, zero-extended to 64 bits.
    function automatic logic [1:0] ent_op(input logic [63:0] e, input int aw, input int dw);
        return e[aw+dw +: 2];
    endfunction

    function automatic logic [31:0] ent_addr(input logic [63:0] e, input int aw, input int dw);
        logic [63:0] m;
        m = (64'd1 << aw) - 64'd1;
        return 32'((e >> dw) & m);
    endfunction

    function automatic logic [31:0] ent_data(input logic [63:0] e, input int dw);
        logic [63:0] m;
        m = (64'd1 << dw) - 64'd1;
        return 32'(e & m);
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sensor_reg_init_timer.sv
// Loadable down-counter shared by power sequencing and DELAY entries.
// done_o is high whenever the count has reached zero.
module init_timer #(
    parameter int W    = 8,
    parameter int INIT = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load overrides counting; the counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register; reset preloads the power-down hold time.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= W'(INIT);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sensor_reg_init.sv
// Camera sensor initialiser: power/reset pin sequencing, then walks an
// external ROM of opcode-tagged entries through the i2c_control handshake.
module sensor_reg_init
    import sensor_init_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int TBL_AW     = 8,
    parameter int ENTRY_W    = 2 + ADDR_W + DATA_W,
    parameter int PWDN_CYC   = 50_000,
    parameter int RST_CYC    = 50_000,
    parameter int SETTLE_CYC = 1_000_000,
    parameter int MS_CYC     = 50_000,
    parameter int MAX_RETRY  = 3
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               start,
    output logic [TBL_AW-1:0]  tbl_addr,
    input  logic [ENTRY_W-1:0] tbl_q,
    output logic               wrreg_req,
    output logic               rdreg_req,
    output logic [15:0]        reg_addr,
    output logic [DATA_W-1:0]  wrdata,
    input  logic [DATA_W-1:0]  rddata,
    input  logic               rw_done,
    input  logic               ack,
    output logic               camera_pwdn,
    output logic               camera_rst_n,
    output logic               init_done,
    output logic               init_err,
    output logic [TBL_AW-1:0]  err_index
);

    localparam int DLY_MAX = ((1 << DATA_W) - 1) * MS_CYC;
    localparam int CYC_MAX = max_i(max_i(PWDN_CYC, RST_CYC), max_i(SETTLE_CYC, DLY_MAX));
    localparam int TMR_W   = $clog2(CYC_MAX + 1);
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e              state_q, state_d;
    logic [TBL_AW-1:0]   idx_q, idx_d;
    logic [TBL_AW-1:0]   eidx_q, eidx_d;
    logic [RTY_W-1:0]    rty_q, rty_d;
    logic [1:0]          op_q, op_d;
    logic [15:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic                wr_q, rd_q;
    logic                pwdn_q, rstn_q;
    logic                done_q, err_q;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_done;

    logic [1:0]          e_op;
    logic [15:0]         e_addr;
    logic [DATA_W-1:0]   e_data;
    logic [31:0]         dly_cyc;

    assign e_op    = ent_op(64'(tbl_q), ADDR_W, DATA_W);
    assign e_addr  = 16'(ent_addr(64'(tbl_q), ADDR_W, DATA_W));
    assign e_data  = DATA_W'(ent_data(64'(tbl_q), DATA_W));
    assign dly_cyc = 32'(e_data) * 32'(MS_CYC);

    init_timer #(
        .W    (TMR_W),
        .INIT (PWDN_CYC - 1)
    ) u_timer (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .done_o (tmr_done)
    );

    // Next-state and datapath updates for the sequencing FSM.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        eidx_d   = eidx_q;
        rty_d    = rty_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            PWR_DN: begin
                if (tmr_done) begin
                    state_d  = RST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(RST_CYC - 1);
                end
            end
            RST_HOLD: begin
                if (tmr_done) begin
                    state_d  = SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                if (tmr_done) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = DECODE;
            end
            DECODE: begin
                op_d   = e_op;
                addr_d = e_addr;
                wd_d   = e_data;
                case (e_op)
                    OP_WRITE,
                    OP_WRITE_VERIFY: state_d = WR;
                    OP_DELAY: begin
                        if (e_data == '0) begin
                            state_d = NEXT;
                        end else begin
                            state_d  = DLY;
                            tmr_load = 1'b1;
                            tmr_val  = TMR_W'(dly_cyc - 32'd1);
                        end
                    end
                    OP_END: state_d = DONE;
                endcase
            end
            WR: begin
                state_d = WAIT_W;
            end
            WAIT_W: begin
                if (rw_done) begin
                    if (ack) begin
                        state_d = RETRY;
                    end else if (op_q == OP_WRITE_VERIFY) begin
                        state_d = RD;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            RD: begin
                state_d = WAIT_R;
            end
            WAIT_R: begin
                if (rw_done) begin
                    if (ack || (rddata != wd_q)) begin
                        state_d = RETRY;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            RETRY: begin
                if (rty_q < RTY_W'(MAX_RETRY)) begin
                    rty_d   = rty_q + 1'b1;
                    state_d = WR;
                end else begin
                    eidx_d  = idx_q;
                    state_d = ERROR;
                end
            end
            NEXT: begin
                rty_d = '0;
                if (idx_q == {TBL_AW{1'b1}}) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FETCH;
                end
            end
            DLY: begin
                if (tmr_done) begin
                    state_d = NEXT;
                end
            end
            DONE, ERROR: begin
                if (start) begin
                    idx_d   = '0;
                    rty_d   = '0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = PWR_DN;
            end
        endcase
    end

    // FSM state and entry registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= PWR_DN;
            idx_q   <= '0;
            eidx_q  <= '0;
            rty_q   <= '0;
            op_q    <= OP_WRITE;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            eidx_q  <= eidx_d;
            rty_q   <= rty_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
        end
    end

    // Registered pins and request pulses, glitch-free toward the sensor.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pwdn_q <= 1'b1;
            rstn_q <= 1'b0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pwdn_q <= (state_d == PWR_DN);
            rstn_q <= !((state_d == PWR_DN) || (state_d == RST_HOLD));
            wr_q   <= (state_q == WR);
            rd_q   <= (state_q == RD);
            done_q <= (state_d == DONE);
            err_q  <= (state_d == ERROR);
        end
    end

    assign tbl_addr     = idx_q;
    assign wrreg_req    = wr_q;
    assign rdreg_req    = rd_q;
    assign reg_addr     = addr_q;
    assign wrdata       = wd_q;
    assign camera_pwdn  = pwdn_q;
    assign camera_rst_n = rstn_q;
    assign init_done    = done_q;
    assign init_err     = err_q;
    assign err_index    = eidx_q;

endmodule

// File: tb/tb_sensor_reg_init.sv
// Bench for sensor_reg_init: table-driven scenarios rerun via start,
// an I2C responder model and a request scoreboard.
module tb_sensor_reg_init;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int TAW  = 4;
    localparam int EW   = 2 + AW + DW;
    localparam int MAXR = 3;
    localparam int NV   = 6;

    typedef struct {
        logic [15:0][EW-1:0] tbl;
        int   nack;
        int   bad;
        logic [7:0] bad_val;
        int   nwr;
        int   nrd;
        bit   done;
        bit   err;
        int   eidx;
        int   g1;
        int   g2;
    } vec_t;

    typedef struct {
        bit         rd;
        logic [15:0] addr;
        logic [7:0] data;
    } req_t;

    logic            Clk;
    logic            Rst_n;
    logic            start;
    logic [TAW-1:0]  tbl_addr;
    logic [EW-1:0]   tbl_q;
    logic            wrreg_req;
    logic            rdreg_req;
    logic [15:0]     reg_addr;
    logic [DW-1:0]   wrdata;
    logic [DW-1:0]   rddata;
    logic            rw_done;
    logic            ack;
    logic            camera_pwdn;
    logic            camera_rst_n;
    logic            init_done;
    logic            init_err;
    logic [TAW-1:0]  err_index;

    sensor_reg_init #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TBL_AW     (TAW),
        .ENTRY_W    (EW),
        .PWDN_CYC   (10),
        .RST_CYC    (20),
        .SETTLE_CYC (30),
        .MS_CYC     (100),
        .MAX_RETRY  (MAXR)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .start        (start),
        .tbl_addr     (tbl_addr),
        .tbl_q        (tbl_q),
        .wrreg_req    (wrreg_req),
        .rdreg_req    (rdreg_req),
        .reg_addr     (reg_addr),
        .wrdata       (wrdata),
        .rddata       (rddata),
        .rw_done      (rw_done),
        .ack          (ack),
        .camera_pwdn  (camera_pwdn),
        .camera_rst_n (camera_rst_n),
        .init_done    (init_done),
        .init_err     (init_err),
        .err_index    (err_index)
    );

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cyc = 0;
    int   resp_cyc = 0;
    int   first_wr = -1;
    int   n_wr = 0;
    int   n_rd = 0;
    int   nack_idx = -1;
    int   pin_bad = 0;
    bit   pend = 0;
    bit   cur_rd = 0;
    bit   hold_resp = 0;
    bit   mon_pins = 0;
    logic [7:0] last_wd = '0;

    logic [EW-1:0] rom [16];
    vec_t          vecs [NV];
    req_t          exp_q [$];
    logic [7:0]    rb_q [$];
    int            gaps [$];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    always @(posedge Clk) tbl_q <= rom[tbl_addr];

    initial forever begin
        @(negedge Clk);
        if (mon_pins && (camera_pwdn || !camera_rst_n)) pin_bad++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] E(input logic [1:0] op, input logic [15:0] a,
                                        input logic [7:0] d);
        return {op, a, d};
    endfunction

    function automatic logic [15:0][EW-1:0] all_end();
        logic [15:0][EW-1:0] t;
        for (int i = 0; i < 16; i++) t[i] = E(2'b11, 16'h0, 8'h0);
        return t;
    endfunction

    function automatic int gap_at(input int i);
        return (gaps.size() > i) ? gaps[i] : -1;
    endfunction

    task automatic push_req(input bit rd, input logic [15:0] a, input logic [7:0] d);
        req_t r;
        r.rd   = rd;
        r.addr = a;
        r.data = d;
        exp_q.push_back(r);
    endtask

    // I2C responder: scoreboard on each request, rw_done 3 cycles later.
    initial begin
        req_t r;
        rw_done = 1'b0;
        ack     = 1'b0;
        rddata  = '0;
        forever begin
            @(negedge Clk);
            rw_done = 1'b0;
            ack     = 1'b0;
            if (!Rst_n) begin
                pend = 1'b0;
            end else if (wrreg_req || rdreg_req) begin
                chk("req_protocol", {30'd0, wrreg_req && rdreg_req, pend}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("req_unexpected", {7'd0, rdreg_req, reg_addr, wrdata}, 32'hFFFF_FFFF);
                end else begin
                    r = exp_q.pop_front();
                    chk("req_match", {7'd0, rdreg_req, reg_addr, wrdata},
                        {7'd0, r.rd, r.addr, r.data});
                end
                gaps.push_back(cyc - done_cyc);
                if (wrreg_req) begin
                    n_wr++;
                    last_wd = wrdata;
                    if (first_wr < 0) first_wr = cyc;
                end else begin
                    n_rd++;
                end
                cur_rd   = rdreg_req;
                pend     = 1'b1;
                resp_cyc = cyc + 3;
            end else if (pend && !hold_resp && cyc == resp_cyc) begin
                rw_done  = 1'b1;
                ack      = (nack_idx >= 0) && (int'(tbl_addr) == nack_idx);
                rddata   = cur_rd ? ((rb_q.size() > 0) ? rb_q.pop_front() : last_wd) : 8'h00;
                done_cyc = cyc;
                pend     = 1'b0;
            end
        end
    end

    task automatic set_vec(input int v, input int nk, input int bd, input logic [7:0] bv,
                           input int nw, input int nr, input bit dn, input bit er,
                           input int ei, input int g1, input int g2);
        vecs[v].tbl     = all_end();
        vecs[v].nack    = nk;
        vecs[v].bad     = bd;
        vecs[v].bad_val = bv;
        vecs[v].nwr     = nw;
        vecs[v].nrd     = nr;
        vecs[v].done    = dn;
        vecs[v].err     = er;
        vecs[v].eidx    = ei;
        vecs[v].g1      = g1;
        vecs[v].g2      = g2;
    endtask

    // Reference walk of the table producing the expected request stream.
    task automatic build_exp(input int v);
        logic [EW-1:0] e;
        logic [1:0]    op;
        bit            stop;
        stop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e  = vecs[v].tbl[i];
            op = e[EW-1 -: 2];
            if (op == 2'b11) stop = 1'b1;
            if (stop || op == 2'b10) continue;
            if (i == vecs[v].nack) begin
                for (int k = 0; k <= MAXR; k++) push_req(1'b0, e[23:8], e[7:0]);
                stop = 1'b1;
            end else if (op == 2'b00) begin
                push_req(1'b0, e[23:8], e[7:0]);
            end else begin
                for (int k = 0; k <= MAXR && k <= vecs[v].bad; k++) begin
                    push_req(1'b0, e[23:8], e[7:0]);
                    push_req(1'b1, e[23:8], e[7:0]);
                end
                if (vecs[v].bad > MAXR) stop = 1'b1;
            end
        end
    endtask

    task automatic setup_vec(input int v);
        for (int i = 0; i < 16; i++) rom[i] = vecs[v].tbl[i];
        nack_idx = vecs[v].nack;
        rb_q.delete();
        for (int i = 0; i < vecs[v].bad; i++) rb_q.push_back(vecs[v].bad_val);
        exp_q.delete();
        gaps.delete();
        n_wr = 0;
        n_rd = 0;
        build_exp(v);
    endtask

    task automatic check_reset(input string t);
        chk({t, "_pwdn"},   32'(camera_pwdn),  32'd1);
        chk({t, "_rstn"},   32'(camera_rst_n), 32'd0);
        chk({t, "_wrreq"},  32'(wrreg_req),    32'd0);
        chk({t, "_rdreq"},  32'(rdreg_req),    32'd0);
        chk({t, "_done"},   32'(init_done),    32'd0);
        chk({t, "_err"},    32'(init_err),     32'd0);
        chk({t, "_eidx"},   32'(err_index),    32'd0);
        chk({t, "_taddr"},  32'(tbl_addr),     32'd0);
        chk({t, "_raddr"},  32'(reg_addr),     32'd0);
        chk({t, "_wrdata"}, 32'(wrdata),       32'd0);
    endtask

    task automatic run_to_end(input int v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge Clk);
            if (init_done || init_err) ok = 1'b1;
        end
        chk($sformatf("v%0d_finish", v), 32'(ok), 32'd1);
        repeat (20) @(negedge Clk);
    endtask

    task automatic check_vec(input int v);
        chk($sformatf("v%0d_done", v), 32'(init_done), 32'(vecs[v].done));
        chk($sformatf("v%0d_err", v),  32'(init_err),  32'(vecs[v].err));
        if (vecs[v].err) chk($sformatf("v%0d_eidx", v), 32'(err_index), vecs[v].eidx);
        chk($sformatf("v%0d_nwr", v),  n_wr, vecs[v].nwr);
        chk($sformatf("v%0d_nrd", v),  n_rd, vecs[v].nrd);
        chk($sformatf("v%0d_left", v), exp_q.size(), 32'd0);
        if (vecs[v].g1 >= 0) chk($sformatf("v%0d_gap1", v), gap_at(1), vecs[v].g1);
        if (vecs[v].g2 >= 0) chk($sformatf("v%0d_gap2", v), gap_at(2), vecs[v].g2);
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("start_clr_done", 32'(init_done), 32'd0);
        chk("start_clr_err",  32'(init_err),  32'd0);
    endtask

    initial begin
        int  r0;
        int  pwdn_fall;
        int  rstn_rise;
        bit  seen;

        Rst_n = 1'b0;
        start = 1'b0;

        set_vec(0, -1, 0, 8'h00, 2, 0, 1'b1, 1'b0, 0, 5, -1);
        vecs[0].tbl[0] = E(2'b00, 16'h3008, 8'h82);
        vecs[0].tbl[1] = E(2'b00, 16'h3103, 8'h11);

        set_vec(1, -1, 1, 8'h60, 2, 2, 1'b1, 1'b0, 0, -1, -1);
        vecs[1].tbl[0] = E(2'b01, 16'h4300, 8'h61);

        set_vec(2, 5, 0, 8'h00, 9, 0, 1'b0, 1'b1, 5, -1, -1);
        for (int i = 0; i < 6; i++) vecs[2].tbl[i] = E(2'b00, 16'h2000 + 16'(i), 8'h10 + 8'(i));

        set_vec(3, -1, 0, 8'h00, 16, 0, 1'b1, 1'b0, 0, 5, -1);
        for (int i = 0; i < 16; i++) vecs[3].tbl[i] = E(2'b00, 16'h3100 + 16'(i), 8'(i));

        set_vec(4, -1, 0, 8'h00, 3, 0, 1'b1, 1'b0, 0, 208, 8);
        vecs[4].tbl[0] = E(2'b00, 16'h1000, 8'h01);
        vecs[4].tbl[1] = E(2'b10, 16'h0000, 8'h02);
        vecs[4].tbl[2] = E(2'b00, 16'h1001, 8'h02);
        vecs[4].tbl[3] = E(2'b10, 16'h0000, 8'h00);
        vecs[4].tbl[4] = E(2'b00, 16'h1002, 8'h03);

        set_vec(5, -1, 4, 8'h00, 6, 4, 1'b0, 1'b1, 2, -1, -1);
        vecs[5].tbl[0] = E(2'b00, 16'h3500, 8'h01);
        vecs[5].tbl[1] = E(2'b00, 16'h3501, 8'h02);
        vecs[5].tbl[2] = E(2'b01, 16'h3502, 8'h5A);

        setup_vec(0);
        repeat (3) @(negedge Clk);
        check_reset("boot_rst");

        @(negedge Clk);
        Rst_n = 1'b1;
        r0 = cyc;
        pwdn_fall = -1;
        rstn_rise = -1;
        for (int k = 0; k < 70; k++) begin
            @(negedge Clk);
            if (!camera_pwdn && pwdn_fall < 0) pwdn_fall = cyc - r0;
            if (camera_rst_n && rstn_rise < 0) rstn_rise = cyc - r0;
        end
        chk("pwdn_fall_cyc", pwdn_fall, 32'd10);
        chk("rstn_rise_cyc", rstn_rise, 32'd30);
        chk("first_wr_cyc", first_wr - r0, 32'd63);
        run_to_end(0);
        check_vec(0);

        mon_pins = 1'b1;
        for (int v = 1; v < NV; v++) begin
            setup_vec(v);
            pulse_start();
            run_to_end(v);
            check_vec(v);
        end
        mon_pins = 1'b0;
        chk("pins_held", pin_bad, 32'd0);

        for (int i = 0; i < 16; i++) rom[i] = E(2'b11, 16'h0, 8'h0);
        rom[0] = E(2'b00, 16'h5555, 8'hAA);
        nack_idx = -1;
        exp_q.delete();
        push_req(1'b0, 16'h5555, 8'hAA);
        n_wr = 0;
        hold_resp = 1'b1;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge Clk);
            if (n_wr == 1) seen = 1'b1;
        end
        chk("midw_req_seen", 32'(seen), 32'd1);
        @(negedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        check_reset("midw_rst");
        repeat (3) @(negedge Clk);
        chk("midw_rst_hold_pwdn", 32'(camera_pwdn), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
